// File: rtl/baudrate_gen_frac.sv
// Fractional baud-rate generator: oversample, bit and mid-bit ticks from a runtime
// divisor of act_int + act_frac/2^FRAC_BITS clocks per oversample tick.
module baudrate_gen_frac #(
  parameter int INT_BITS     = 16,
  parameter int FRAC_BITS    = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_INT  = 162,
  parameter int DEFAULT_FRAC = 12
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_sync,
  input  logic                 i_div_wr,
  input  logic [INT_BITS-1:0]  i_div_int,
  input  logic [FRAC_BITS-1:0] i_div_frac,
  output logic                 o_os_tick,
  output logic                 o_bit_tick,
  output logic                 o_mid_tick,
  output logic                 o_div_busy
);

  localparam int                   OS_BITS  = $clog2(OVERSAMPLE);
  localparam int                   PW       = INT_BITS + 1;
  localparam logic [INT_BITS-1:0]  MIN_INT  = INT_BITS'(2);
  localparam logic [INT_BITS-1:0]  RST_INT  = (DEFAULT_INT < 2) ? MIN_INT : INT_BITS'(DEFAULT_INT);
  localparam logic [FRAC_BITS-1:0] RST_FRAC = FRAC_BITS'(DEFAULT_FRAC);
  localparam logic [OS_BITS-1:0]   OS_ONE   = OS_BITS'(1);
  localparam logic [OS_BITS-1:0]   OS_MID   = OS_BITS'(OVERSAMPLE / 2);
  localparam logic [PW-1:0]        P_ONE    = PW'(1);

  logic [INT_BITS-1:0]  act_int, sh_int, new_int, wr_int;
  logic [FRAC_BITS-1:0] act_frac, sh_frac, new_frac;
  logic                 pend;
  logic [PW-1:0]        cnt, p, p_tick;
  logic [FRAC_BITS-1:0] acc;
  logic [FRAC_BITS:0]   acc_sum;
  logic [OS_BITS-1:0]   os, os_nxt;
  logic                 boundary, apply_pt, do_apply;

  assign wr_int   = (i_div_int < MIN_INT) ? MIN_INT : i_div_int;
  assign boundary = i_en && !i_sync && (cnt == p - P_ONE);
  // Any of these is a safe point to swap divisors without cutting a period short.
  assign apply_pt = boundary || i_sync || !i_en;
  assign do_apply = apply_pt && (pend || i_div_wr);

  always_comb begin
    new_int  = act_int;
    new_frac = act_frac;
    if (do_apply) begin
      if (i_div_wr) begin
        new_int  = wr_int;
        new_frac = i_div_frac;
      end else begin
        new_int  = sh_int;
        new_frac = sh_frac;
      end
    end
  end

  assign acc_sum    = {1'b0, acc} + {1'b0, new_frac};
  assign p_tick     = {1'b0, new_int} + {{INT_BITS{1'b0}}, acc_sum[FRAC_BITS]};
  assign os_nxt     = os + OS_ONE;
  assign o_div_busy = pend;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      act_int    <= RST_INT;
      act_frac   <= RST_FRAC;
      sh_int     <= RST_INT;
      sh_frac    <= RST_FRAC;
      pend       <= 1'b0;
      cnt        <= '0;
      p          <= {1'b0, RST_INT};
      acc        <= '0;
      os         <= '0;
      o_os_tick  <= 1'b0;
      o_bit_tick <= 1'b0;
      o_mid_tick <= 1'b0;
    end else begin
      o_os_tick  <= 1'b0;
      o_bit_tick <= 1'b0;
      o_mid_tick <= 1'b0;
      act_int    <= new_int;
      act_frac   <= new_frac;

      if (i_div_wr && !apply_pt) begin
        sh_int  <= wr_int;
        sh_frac <= i_div_frac;
        pend    <= 1'b1;
      end else if (apply_pt) begin
        pend <= 1'b0;
      end

      if (i_sync) begin
        cnt <= '0;
        acc <= '0;
        os  <= '0;
        p   <= {1'b0, new_int};
      end else if (!i_en) begin
        // Counters freeze so the interrupted period resumes; only a fresh divisor restarts acc.
        if (do_apply) acc <= '0;
      end else if (boundary) begin
        cnt        <= '0;
        acc        <= acc_sum[FRAC_BITS-1:0];
        os         <= os_nxt;
        p          <= p_tick;
        o_os_tick  <= 1'b1;
        o_bit_tick <= (os_nxt == '0);
        o_mid_tick <= (os_nxt == OS_MID);
      end else begin
        cnt <= cnt + P_ONE;
      end
    end
  end

endmodule

// File: tb/tb_baudrate_gen_frac.sv
// Self-checking bench for baudrate_gen_frac: tick times are predicted from the closed-form
// cumulative period n*int + floor((n-1)*frac/2^FRAC_BITS) after each phase epoch.
module tb_baudrate_gen_frac;

  localparam int INT_BITS   = 16;
  localparam int FRAC_BITS  = 4;
  localparam int OVERSAMPLE = 16;
  localparam int DEF_INT    = 162;
  localparam int DEF_FRAC   = 12;
  localparam int FDEN       = 1 << FRAC_BITS;
  localparam int MAXC       = 16384;

  logic                 i_clk = 1'b0;
  logic                 i_reset;
  logic                 i_en;
  logic                 i_sync;
  logic                 i_div_wr;
  logic [INT_BITS-1:0]  i_div_int;
  logic [FRAC_BITS-1:0] i_div_frac;
  logic                 o_os_tick;
  logic                 o_bit_tick;
  logic                 o_mid_tick;
  logic                 o_div_busy;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic os_hist   [MAXC];
  logic bit_hist  [MAXC];
  logic mid_hist  [MAXC];
  logic busy_hist [MAXC];

  baudrate_gen_frac #(
    .INT_BITS    (INT_BITS),
    .FRAC_BITS   (FRAC_BITS),
    .OVERSAMPLE  (OVERSAMPLE),
    .DEFAULT_INT (DEF_INT),
    .DEFAULT_FRAC(DEF_FRAC)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_sync    (i_sync),
    .i_div_wr  (i_div_wr),
    .i_div_int (i_div_int),
    .i_div_frac(i_div_frac),
    .o_os_tick (o_os_tick),
    .o_bit_tick(o_bit_tick),
    .o_mid_tick(o_mid_tick),
    .o_div_busy(o_div_busy)
  );

  always #5 i_clk = ~i_clk;

  // cyc = number of rising edges so far; outputs are logged mid-cycle under that index.
  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (cyc < MAXC) begin
      os_hist[cyc]   <= o_os_tick;
      bit_hist[cyc]  <= o_bit_tick;
      mid_hist[cyc]  <= o_mid_tick;
      busy_hist[cyc] <= o_div_busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: the n-th tick after an epoch edge s (cnt=0, acc=0, P=int).
  function automatic int exp_tick(int s, int iv, int fv, int n);
    return s + n * iv + ((n - 1) * fv) / FDEN;
  endfunction

  function automatic int nth_tick(int lo, int n);
    int seen = 0;
    for (int t = lo + 1; t < MAXC; t++) begin
      if (os_hist[t] === 1'b1) begin
        seen++;
        if (seen == n) return t;
      end
    end
    return -1;
  endfunction

  function automatic int count_in(int which, int lo, int hi);
    int c = 0;
    for (int t = lo + 1; t <= hi && t < MAXC; t++) begin
      case (which)
        0:       c += (os_hist[t] === 1'b1) ? 1 : 0;
        1:       c += (bit_hist[t] === 1'b1) ? 1 : 0;
        2:       c += (mid_hist[t] === 1'b1) ? 1 : 0;
        default: c += (busy_hist[t] === 1'b1) ? 1 : 0;
      endcase
    end
    return c;
  endfunction

  task automatic wait_until(input int c);
    if (c >= MAXC - 2) begin
      $display("FAIL cycle_budget: needed %0d limit %0d", c, MAXC - 2);
      $fatal(1, "cycle budget");
    end
    while (cyc < c) @(negedge i_clk);
  endtask

  // Returns at the negedge just before edge e, so inputs set now are sampled at edge e.
  task automatic at_edge(input int e);
    wait_until(e - 1);
  endtask

  task automatic sync_write(input int iv, input int fv, output int s);
    @(negedge i_clk);
    i_sync     = 1'b1;
    i_div_wr   = 1'b1;
    i_div_int  = INT_BITS'(iv);
    i_div_frac = FRAC_BITS'(fv);
    s = cyc + 1;
    @(negedge i_clk);
    i_sync   = 1'b0;
    i_div_wr = 1'b0;
  endtask

  task automatic pulse_write(input int e, input int iv, input int fv);
    at_edge(e);
    i_div_wr   = 1'b1;
    i_div_int  = INT_BITS'(iv);
    i_div_frac = FRAC_BITS'(fv);
    @(negedge i_clk);
    i_div_wr = 1'b0;
  endtask

  task automatic test_reset;
    int s, got, exp_t;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_os_tick, o_bit_tick, o_mid_tick, o_div_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {o_os_tick, o_bit_tick, o_mid_tick, o_div_busy});
    end
    i_reset = 1'b0;
    s = cyc;
    wait_until(exp_tick(s, DEF_INT, DEF_FRAC, 3) + 2);
    for (int n = 1; n <= 3; n++) begin
      got = nth_tick(s, n);
      exp_t = exp_tick(s, DEF_INT, DEF_FRAC, n);
      checks++;
      if (got !== exp_t) begin
        errors++;
        $display("FAIL reset_default_tick%0d: got cycle %0d expected %0d", n, got, exp_t);
      end
    end
    checks++;
    if (count_in(3, s, cyc - 1) !== 0) begin
      errors++;
      $display("FAIL reset_busy: got %0d busy cycles expected 0", count_in(3, s, cyc - 1));
    end
  endtask

  task automatic test_integer;
    int s, t;
    sync_write(4, 0, s);
    wait_until(exp_tick(s, 4, 0, 64) + 2);
    for (int n = 1; n <= 64; n++) begin
      t = exp_tick(s, 4, 0, n);
      checks++;
      if (os_hist[t] !== 1'b1 || bit_hist[t] !== (n % OVERSAMPLE == 0) ||
          mid_hist[t] !== (n % OVERSAMPLE == OVERSAMPLE / 2)) begin
        errors++;
        $display("FAIL int_tick%0d: got os/bit/mid %b%b%b at cycle %0d expected 1%b%b", n,
                 os_hist[t], bit_hist[t], mid_hist[t], t, (n % OVERSAMPLE == 0), (n % OVERSAMPLE == OVERSAMPLE / 2));
      end
    end
    t = exp_tick(s, 4, 0, 64);
    checks++;
    if (count_in(0, s, t) !== 64 || count_in(1, s, t) !== 4 || count_in(2, s, t) !== 4) begin
      errors++;
      $display("FAIL int_counts: got os=%0d bit=%0d mid=%0d expected 64 4 4",
               count_in(0, s, t), count_in(1, s, t), count_in(2, s, t));
    end
  endtask

  task automatic test_fractional;
    int s, got, exp_t;
    sync_write(4, 8, s);
    wait_until(exp_tick(s, 4, 8, 33) + 2);
    for (int n = 1; n <= 33; n++) begin
      got = nth_tick(s, n);
      exp_t = exp_tick(s, 4, 8, n);
      checks++;
      if (got !== exp_t) begin
        errors++;
        $display("FAIL frac_tick%0d: got cycle %0d expected %0d", n, got, exp_t);
      end
    end
    checks++;
    if (nth_tick(s, 17) - nth_tick(s, 1) !== 72) begin
      errors++;
      $display("FAIL frac_span16: got %0d cycles expected 72", nth_tick(s, 17) - nth_tick(s, 1));
    end
  endtask

  task automatic test_div_change;
    int s;
    int exp_os[7];
    int busy_c[6];
    logic busy_v[6];
    exp_os = '{10, 16, 22, 28, 33, 38, 43};
    busy_c = '{4, 9, 10, 24, 27, 28};
    busy_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sync_write(10, 0, s);
    pulse_write(s + 4, 6, 0);
    pulse_write(s + 24, 7, 0);
    pulse_write(s + 25, 5, 0);
    wait_until(s + 46);
    foreach (exp_os[k]) begin
      checks++;
      if (os_hist[s + exp_os[k]] !== 1'b1) begin
        errors++;
        $display("FAIL chg_tick@+%0d: got %b expected 1", exp_os[k], os_hist[s + exp_os[k]]);
      end
    end
    checks++;
    if (count_in(0, s, s + 43) !== 7) begin
      errors++;
      $display("FAIL chg_count: got %0d ticks expected 7", count_in(0, s, s + 43));
    end
    foreach (busy_c[k]) begin
      checks++;
      if (busy_hist[s + busy_c[k]] !== busy_v[k]) begin
        errors++;
        $display("FAIL chg_busy@+%0d: got %b expected %b", busy_c[k], busy_hist[s + busy_c[k]], busy_v[k]);
      end
    end
  endtask

  task automatic test_sync_en;
    int s, s2, t;
    sync_write(5, 0, s);
    at_edge(s + 10);
    i_sync = 1'b1;
    s2 = s + 10;
    @(negedge i_clk);
    i_sync = 1'b0;
    wait_until(exp_tick(s2, 5, 0, 16) + 2);
    checks++;
    if (os_hist[s + 5] !== 1'b1 || os_hist[s2] !== 1'b0) begin
      errors++;
      $display("FAIL sync_no_tick: got pre=%b at_sync=%b expected 1 0", os_hist[s + 5], os_hist[s2]);
    end
    for (int n = 1; n <= 16; n++) begin
      t = exp_tick(s2, 5, 0, n);
      checks++;
      if (os_hist[t] !== 1'b1) begin
        errors++;
        $display("FAIL sync_tick%0d: got %b at cycle %0d expected 1", n, os_hist[t], t);
      end
    end
    t = exp_tick(s2, 5, 0, 16);
    checks++;
    if (bit_hist[t] !== 1'b1 || count_in(1, s2, t) !== 1) begin
      errors++;
      $display("FAIL sync_bit: got bit=%b count=%0d expected 1 1", bit_hist[t], count_in(1, s2, t));
    end

    sync_write(7, 0, s);
    at_edge(s + 3);
    i_en = 1'b0;
    pulse_write(s + 10, 3, 0);
    at_edge(s + 23);
    i_en = 1'b1;
    wait_until(s + 36);
    checks++;
    if (count_in(0, s, s + 26) !== 0) begin
      errors++;
      $display("FAIL en_hold: got %0d ticks expected 0", count_in(0, s, s + 26));
    end
    checks++;
    if (nth_tick(s, 1) !== s + 27 || nth_tick(s, 2) !== s + 30 || nth_tick(s, 3) !== s + 33) begin
      errors++;
      $display("FAIL en_resume: got +%0d +%0d +%0d expected +27 +30 +33",
               nth_tick(s, 1) - s, nth_tick(s, 2) - s, nth_tick(s, 3) - s);
    end
    checks++;
    if (count_in(3, s, s + 33) !== 0) begin
      errors++;
      $display("FAIL en_busy: got %0d busy cycles expected 0", count_in(3, s, s + 33));
    end
  endtask

  task automatic test_clamp;
    int s;
    sync_write(0, 0, s);
    wait_until(s + 18);
    for (int n = 1; n <= 8; n++) begin
      checks++;
      if (nth_tick(s, n) !== exp_tick(s, 2, 0, n)) begin
        errors++;
        $display("FAIL clamp_tick%0d: got cycle %0d expected %0d", n, nth_tick(s, n), exp_tick(s, 2, 0, n));
      end
    end
  endtask

  task automatic test_random;
    int s, iv, fv, nt, t, got;
    for (int r = 0; r < 6; r++) begin
      iv = int'($urandom_range(2, 12));
      fv = int'($urandom_range(0, FDEN - 1));
      nt = int'($urandom_range(16, 40));
      repeat ($urandom_range(0, 7)) @(negedge i_clk);
      sync_write(iv, fv, s);
      wait_until(exp_tick(s, iv, fv, nt) + 2);
      for (int n = 1; n <= nt; n++) begin
        t = exp_tick(s, iv, fv, n);
        got = nth_tick(s, n);
        checks++;
        if (got !== t || bit_hist[t] !== (n % OVERSAMPLE == 0) ||
            mid_hist[t] !== (n % OVERSAMPLE == OVERSAMPLE / 2)) begin
          errors++;
          $display("FAIL rand%0d_tick%0d (int=%0d frac=%0d): got cycle %0d bit=%b mid=%b expected %0d", r, n,
                   iv, fv, got, bit_hist[t], mid_hist[t], t);
        end
      end
      t = exp_tick(s, iv, fv, nt);
      checks++;
      if (count_in(1, s, t) !== nt / OVERSAMPLE || count_in(2, s, t) !== (nt + OVERSAMPLE / 2) / OVERSAMPLE) begin
        errors++;
        $display("FAIL rand%0d_bitmid: got bit=%0d mid=%0d expected %0d %0d", r, count_in(1, s, t),
                 count_in(2, s, t), nt / OVERSAMPLE, (nt + OVERSAMPLE / 2) / OVERSAMPLE);
      end
    end
  endtask

  task automatic test_reset_mid;
    int s, got, exp_t;
    sync_write(9, 0, s);
    pulse_write(s + 11, 3, 0);
    at_edge(s + 13);
    checks++;
    if (o_div_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy_before: got %b expected 1", o_div_busy);
    end
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_os_tick, o_bit_tick, o_mid_tick, o_div_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_outputs: got %b expected 0000", {o_os_tick, o_bit_tick, o_mid_tick, o_div_busy});
    end
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    s = cyc;
    wait_until(exp_tick(s, DEF_INT, DEF_FRAC, 3) + 2);
    for (int n = 1; n <= 3; n++) begin
      got = nth_tick(s, n);
      exp_t = exp_tick(s, DEF_INT, DEF_FRAC, n);
      checks++;
      if (got !== exp_t) begin
        errors++;
        $display("FAIL rmid_default_tick%0d: got cycle %0d expected %0d", n, got, exp_t);
      end
    end
    checks++;
    if (count_in(3, s, cyc - 1) !== 0) begin
      errors++;
      $display("FAIL rmid_busy_after: got %0d busy cycles expected 0", count_in(3, s, cyc - 1));
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_en       = 1'b1;
    i_sync     = 1'b0;
    i_div_wr   = 1'b0;
    i_div_int  = '0;
    i_div_frac = '0;
    test_reset();
    test_integer();
    test_fractional();
    test_div_change();
    test_sync_en();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
